cevre_istek_birimi: RTL
=======================

CEVRE_ISTEK_BIRIMI -- requirements
Module: cevre_istek_birimi

Interface
REQ-001 SHALL have parameter ZAMAN_ASIMI, default 1024, meaning the cycles an outstanding request may wait before a timeout error; legal range 2..65535.
REQ-002 SHALL have ports clk_i input 1 clock; rstn_i input 1 reset, asynchronous active-low.
REQ-003 SHALL have ports bellek_istek_gecerli_i input 1; bellek_istek_hazir_o output 1: core request handshake.
REQ-004 SHALL have ports bellek_adres_i input `ADRES_BIT; bellek_veri_i input `VERI_BIT; bellek_maske_i input 4; bellek_yaz_i input 1: core request payload, where yaz=1 means store.
REQ-005 SHALL have ports bellek_yanit_gecerli_o output 1; bellek_yanit_veri_o output `VERI_BIT; bellek_yanit_hata_o output 1: core response, with no backpressure.
REQ-006 SHALL have ports cek_adres_o output `ADRES_BIT; cek_veri_o output `VERI_BIT; cek_tilefields_o output `TL_A_BITS; cek_gecerli_o output 1; cek_hazir_i input 1: peripheral TL-UL A channel.
REQ-007 SHALL have ports cevre_veri_i input `VERI_BIT; cevre_gecerli_i input 1; cevre_tilefields_i input `TL_D_BITS; cevre_hazir_o output 1: peripheral TL-UL D channel.

Function
REQ-008 SHALL run an FSM with states BOSTA, ISTEK, YANIT, and at most one outstanding transaction.
REQ-009 SHALL drive bellek_istek_hazir_o=1 only in BOSTA.
REQ-010 In BOSTA, a handshake (gecerli&hazir) SHALL register address, data, mask and op, and SHALL enter ISTEK the next cycle.
REQ-011 SHALL encode op as: load -> TL_OP_GET; store with mask 4'b1111 -> TL_OP_PUT_FULL; any other store mask -> TL_OP_PUT_PART.
REQ-012 SHALL fill the A fields as: TL_A_SIZE=2, TL_A_MASK=registered mask (4'b1111 for loads), TL_A_SOURCE=4-bit tag.
REQ-013 In ISTEK, cek_gecerli_o=1 and all A outputs SHALL stay stable until cek_hazir_i=1; on that cycle the FSM SHALL move to YANIT and the tag SHALL increment, wrapping 15->0.
REQ-014 SHALL tie cevre_hazir_o to 1; a D beat is consumed whenever cevre_gecerli_i=1.
REQ-015 In YANIT, a D beat whose source equals the issued tag SHALL complete the transaction; any other D beat, in any state, SHALL be dropped silently.
REQ-016 On completion, the next cycle SHALL assert bellek_yanit_gecerli_o for exactly one cycle, and the FSM SHALL return to BOSTA on that same cycle.
REQ-017 On completion, the response data SHALL be cevre_veri_i for GET and 0 for stores.
REQ-018 On completion, hata=1 SHALL be set when the D op mismatches the request: GET expects TL_OP_ACK_DATA, PUT expects TL_OP_ACK.
REQ-019 Minimum latency SHALL be: core handshake at cycle 0, cek_gecerli_o at cycle 1, D beat at cycle 2, bellek_yanit_gecerli_o at cycle 3.
REQ-020 bellek_yanit_veri_o and bellek_yanit_hata_o SHALL hold their last values while gecerli=0.

Reset
REQ-021 Asserting rstn_i low SHALL immediately force: state BOSTA, cek_gecerli_o=0, bellek_yanit_gecerli_o=0, hata=0, response data 0, tag 0, timeout counter 0, A outputs 0.
REQ-022 Reset mid-transaction SHALL abandon the transaction, produce no core response, and drop any later D beat for the old tag.

Configuration
REQ-023 With CEVRE_ZAMAN_ASIMI_EN defined, a counter SHALL clear on entry to ISTEK and increment each cycle in ISTEK/YANIT.
REQ-024 With CEVRE_ZAMAN_ASIMI_EN defined, when the counter reaches ZAMAN_ASIMI-1 without completion, the next cycle SHALL deassert cek_gecerli_o, pulse yanit with hata=1 and data 32'hDEADBEEF, and enter BOSTA.
REQ-025 With CEVRE_ZAMAN_ASIMI_EN defined, if completion and timeout coincide, completion SHALL win.
REQ-026 Without CEVRE_ZAMAN_ASIMI_EN, no counter logic SHALL exist, the FSM SHALL wait indefinitely, and hata SHALL arise only from REQ-018.

Structure
REQ-027 TL op codes, the TL_A_*/TL_D_* field slices, `ADRES_BIT/`VERI_BIT and LOW/HIGH SHALL come from the shared header sabitler.vh; the FSM state localparams SHALL be local.
REQ-028 The timeout counter SHALL be one sub-module, zaman_asimi_sayaci (clear, enable, terminal-count output), instantiated only under CEVRE_ZAMAN_ASIMI_EN.
REQ-029 The design SHALL be a single always-comb/always-ff pair otherwise, with no other sub-modules.

Verification
REQ-030 Store 0x41 to 0x2000_000C with mask 4'b1111 and cek_hazir_i=1, D ACK at cycle 2 -> PUT_FULL, source 0, yanit at cycle 3, data 0, hata 0.
REQ-031 Load from 0x2000_0008, hazir held low for 5 cycles, D ACK_DATA 0x0000_0008 -> A payload stable for all 6 cycles, yanit data 0x8, hata 0.
REQ-032 Store with mask 4'b0001 -> PUT_PART, mask 4'b0001 on the A channel; load answered with ACK -> hata=1.
REQ-033 16 back-to-back loads -> sources 0..15, then 0 again; a D beat with source 3 injected while waiting on tag 4 -> dropped, no yanit.
REQ-034 With CEVRE_ZAMAN_ASIMI_EN and ZAMAN_ASIMI=8, no D beat -> yanit hata=1, data 0xDEADBEEF, 8 cycles after ISTEK entry; a late D beat is ignored.
REQ-035 Reset pulse while in YANIT -> outputs at reset values within the same cycle, no response, the next request uses tag 0.

Source files
------------

// File: rtl/cevre_istek_birimi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cevre_istek_birimi_pkg
//  Description : Shared constants for the peripheral request unit: bus
//                widths, TL-UL op codes, A/D channel field layout and
//                small pack/unpack helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package cevre_istek_birimi_pkg;

    localparam int ADRES_BIT = 32;
    localparam int VERI_BIT  = 32;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    // TL-UL op codes (A channel requests, D channel acknowledges)
    localparam logic [2:0] TL_OP_PUT_FULL = 3'd0;
    localparam logic [2:0] TL_OP_PUT_PART = 3'd1;
    localparam logic [2:0] TL_OP_GET      = 3'd4;
    localparam logic [2:0] TL_OP_ACK      = 3'd0;
    localparam logic [2:0] TL_OP_ACK_DATA = 3'd1;

    // A channel field layout: {opcode, size, mask, source}
    localparam int TL_A_BITS       = 13;
    localparam int TL_A_OP_MSB     = 12;
    localparam int TL_A_OP_LSB     = 10;
    localparam int TL_A_SIZE_MSB   = 9;
    localparam int TL_A_SIZE_LSB   = 8;
    localparam int TL_A_MASK_MSB   = 7;
    localparam int TL_A_MASK_LSB   = 4;
    localparam int TL_A_SOURCE_MSB = 3;
    localparam int TL_A_SOURCE_LSB = 0;

    // D channel field layout: {opcode, source}
    localparam int TL_D_BITS       = 7;
    localparam int TL_D_OP_MSB     = 6;
    localparam int TL_D_OP_LSB     = 4;
    localparam int TL_D_SOURCE_MSB = 3;
    localparam int TL_D_SOURCE_LSB = 0;

    // Every access is a full 32-bit word (2^2 bytes)
    localparam logic [1:0] TL_BOYUT_4B = 2'd2;

    // Response data reported when a request times out
    localparam logic [VERI_BIT-1:0] ZAMAN_ASIMI_VERI = 32'hDEAD_BEEF;

    // Loads become GET; stores are full or partial depending on the mask
    function automatic logic [2:0] tl_op_kodla(input logic yaz, input logic [3:0] maske);
        if (!yaz) begin
            return TL_OP_GET;
        end
        return (maske == 4'b1111) ? TL_OP_PUT_FULL : TL_OP_PUT_PART;
    endfunction

    function automatic logic [TL_A_BITS-1:0] tl_a_paketle(
        input logic [2:0] op,
        input logic [1:0] boyut,
        input logic [3:0] maske,
        input logic [3:0] kaynak
    );
        logic [TL_A_BITS-1:0] a;
        a = '0;
        a[TL_A_OP_MSB:TL_A_OP_LSB]         = op;
        a[TL_A_SIZE_MSB:TL_A_SIZE_LSB]     = boyut;
        a[TL_A_MASK_MSB:TL_A_MASK_LSB]     = maske;
        a[TL_A_SOURCE_MSB:TL_A_SOURCE_LSB] = kaynak;
        return a;
    endfunction

    function automatic logic [2:0] tl_d_op(input logic [TL_D_BITS-1:0] d);
        return d[TL_D_OP_MSB:TL_D_OP_LSB];
    endfunction

    function automatic logic [3:0] tl_d_kaynak(input logic [TL_D_BITS-1:0] d);
        return d[TL_D_SOURCE_MSB:TL_D_SOURCE_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cevre_istek_birimi_zaman_asimi_sayaci.sv
`default_nettype none
// ============================================================================
//  Module      : zaman_asimi_sayaci
//  Description : Wait-cycle counter for an outstanding peripheral request.
//                Synchronous clear, count enable, terminal count flag raised
//                while enabled and the count equals ZAMAN_ASIMI-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module zaman_asimi_sayaci #(
    parameter int ZAMAN_ASIMI = 1024
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic temizle_i,
    input  logic etkin_i,
    output logic bitti_o
);

    localparam logic [15:0] SON_DEGER = 16'(ZAMAN_ASIMI - 1);

    logic [15:0] sayac_q;

    // Count wait cycles; clear has priority so a new request starts from zero
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sayac_q <= '0;
        end else if (temizle_i) begin
            sayac_q <= '0;
        end else if (etkin_i) begin
            sayac_q <= sayac_q + 16'd1;
        end
    end

    assign bitti_o = etkin_i && (sayac_q == SON_DEGER);

endmodule
`default_nettype wire

// File: rtl/cevre_istek_birimi.sv
`default_nettype none
// ============================================================================
//  Module      : cevre_istek_birimi
//  Description : Bridges single core memory requests onto a TL-UL peripheral
//                port. One outstanding transaction, 4-bit rotating source
//                tag, response carries read data and an op-mismatch error.
//                Optional request timeout enabled by CEVRE_ZAMAN_ASIMI_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cevre_istek_birimi
    import cevre_istek_birimi_pkg::*;
#(
    parameter int ZAMAN_ASIMI = 1024
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 bellek_istek_gecerli_i,
    output logic                 bellek_istek_hazir_o,
    input  logic [ADRES_BIT-1:0] bellek_adres_i,
    input  logic [VERI_BIT-1:0]  bellek_veri_i,
    input  logic [3:0]           bellek_maske_i,
    input  logic                 bellek_yaz_i,
    output logic                 bellek_yanit_gecerli_o,
    output logic [VERI_BIT-1:0]  bellek_yanit_veri_o,
    output logic                 bellek_yanit_hata_o,
    output logic [ADRES_BIT-1:0] cek_adres_o,
    output logic [VERI_BIT-1:0]  cek_veri_o,
    output logic [TL_A_BITS-1:0] cek_tilefields_o,
    output logic                 cek_gecerli_o,
    input  logic                 cek_hazir_i,
    input  logic [VERI_BIT-1:0]  cevre_veri_i,
    input  logic                 cevre_gecerli_i,
    input  logic [TL_D_BITS-1:0] cevre_tilefields_i,
    output logic                 cevre_hazir_o
);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTEK = 2'd1,
        YANIT = 2'd2
    } durum_t;

    if (ZAMAN_ASIMI < 2 || ZAMAN_ASIMI > 65535) begin : g_parametre_kontrol
        $error("ZAMAN_ASIMI must be within 2..65535");
    end

    durum_t                durum_q, durum_d;
    logic [ADRES_BIT-1:0]  adres_q, adres_d;
    logic [VERI_BIT-1:0]   veri_q, veri_d;
    logic [3:0]            maske_q, maske_d;
    logic [2:0]            op_q, op_d;
    logic [3:0]            tag_q, tag_d;
    logic                  yanit_gecerli_q, yanit_gecerli_d;
    logic [VERI_BIT-1:0]   yanit_veri_q, yanit_veri_d;
    logic                  yanit_hata_q, yanit_hata_d;

    // The tag advances when the A beat is accepted, so the tag in flight is one behind
    logic [3:0] w_verilen_tag;
    assign w_verilen_tag = tag_q - 4'd1;

`ifdef CEVRE_ZAMAN_ASIMI_EN
    logic w_sayac_temizle;
    logic w_sayac_etkin;
    logic w_zaman_doldu;

    assign w_sayac_temizle = (durum_q == BOSTA) && bellek_istek_gecerli_i;
    assign w_sayac_etkin   = (durum_q != BOSTA);

    zaman_asimi_sayaci #(
        .ZAMAN_ASIMI (ZAMAN_ASIMI)
    ) u_zaman_asimi_sayaci (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .temizle_i (w_sayac_temizle),
        .etkin_i   (w_sayac_etkin),
        .bitti_o   (w_zaman_doldu)
    );
`endif

    // Next-state logic: accept core request, issue A beat, wait for matching D beat
    always_comb begin
        durum_d         = durum_q;
        adres_d         = adres_q;
        veri_d          = veri_q;
        maske_d         = maske_q;
        op_d            = op_q;
        tag_d           = tag_q;
        yanit_gecerli_d = LOW;
        yanit_veri_d    = yanit_veri_q;
        yanit_hata_d    = yanit_hata_q;

        case (durum_q)
            BOSTA: begin
                if (bellek_istek_gecerli_i) begin
                    adres_d = bellek_adres_i;
                    veri_d  = bellek_veri_i;
                    maske_d = bellek_yaz_i ? bellek_maske_i : 4'b1111;
                    op_d    = tl_op_kodla(bellek_yaz_i, bellek_maske_i);
                    durum_d = ISTEK;
                end
            end
            ISTEK: begin
                if (cek_hazir_i) begin
                    tag_d   = tag_q + 4'd1;
                    durum_d = YANIT;
                end
            end
            YANIT: begin
                if (cevre_gecerli_i && (tl_d_kaynak(cevre_tilefields_i) == w_verilen_tag)) begin
                    durum_d         = BOSTA;
                    yanit_gecerli_d = HIGH;
                    if (op_q == TL_OP_GET) begin
                        yanit_veri_d = cevre_veri_i;
                        yanit_hata_d = (tl_d_op(cevre_tilefields_i) != TL_OP_ACK_DATA);
                    end else begin
                        yanit_veri_d = '0;
                        yanit_hata_d = (tl_d_op(cevre_tilefields_i) != TL_OP_ACK);
                    end
                end
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase

`ifdef CEVRE_ZAMAN_ASIMI_EN
        // A completion on the terminal cycle takes precedence over the timeout
        if (w_zaman_doldu && !yanit_gecerli_d) begin
            durum_d         = BOSTA;
            tag_d           = tag_q;
            yanit_gecerli_d = HIGH;
            yanit_veri_d    = ZAMAN_ASIMI_VERI;
            yanit_hata_d    = HIGH;
        end
`endif
    end

    // State and payload registers, cleared immediately by reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q         <= BOSTA;
            adres_q         <= '0;
            veri_q          <= '0;
            maske_q         <= '0;
            op_q            <= '0;
            tag_q           <= '0;
            yanit_gecerli_q <= LOW;
            yanit_veri_q    <= '0;
            yanit_hata_q    <= LOW;
        end else begin
            durum_q         <= durum_d;
            adres_q         <= adres_d;
            veri_q          <= veri_d;
            maske_q         <= maske_d;
            op_q            <= op_d;
            tag_q           <= tag_d;
            yanit_gecerli_q <= yanit_gecerli_d;
            yanit_veri_q    <= yanit_veri_d;
            yanit_hata_q    <= yanit_hata_d;
        end
    end

    assign bellek_istek_hazir_o   = (durum_q == BOSTA);
    assign cek_gecerli_o          = (durum_q == ISTEK);
    assign cek_adres_o            = cek_gecerli_o ? adres_q : '0;
    assign cek_veri_o             = cek_gecerli_o ? veri_q : '0;
    assign cek_tilefields_o       = cek_gecerli_o ? tl_a_paketle(op_q, TL_BOYUT_4B, maske_q, tag_q) : '0;
    assign cevre_hazir_o          = HIGH;
    assign bellek_yanit_gecerli_o = yanit_gecerli_q;
    assign bellek_yanit_veri_o    = yanit_veri_q;
    assign bellek_yanit_hata_o    = yanit_hata_q;

endmodule
`default_nettype wire
